// File: rtl/tu_clock_rate_check.sv
// Clock-rate test unit: counts rising edges of a monitored strobe over
// ROUNDS consecutive windows and passes only if every window is in range.
module tu_clock_rate_check #(
    parameter int WINDOW  = 1024,
    parameter int ROUNDS  = 4,
    parameter int SETTLE  = 16,
    parameter int EXP_MIN = 100,
    parameter int EXP_MAX = 140,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic                      from_up_pass,
    input  logic                      mon_sig,
    output logic                      to_down_pass,
    output logic                      fail,
    output logic                      busy,
    output logic [CNT_W-1:0]          last_count,
    output logic [$clog2(ROUNDS):0]   round_idx
);

    localparam int TMAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int RND_W = $clog2(ROUNDS) + 1;
    localparam logic [31:0] MIN_U = EXP_MIN;
    localparam logic [31:0] MAX_U = EXP_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_MEASURE, S_CHECK, S_PASS, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic               mon_q;
    logic               pass_q, fail_q, busy_q;
    logic               rise;
    logic               in_range;
    logic [CNT_W-1:0]   cnt_inc;

    assign rise     = mon_sig & ~mon_q;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(rise);
    assign in_range = (32'(cnt_q) >= MIN_U) && (32'(cnt_q) <= MAX_U);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (from_up_pass) begin
                    tmr_d   = '0;
                    state_d = (SETTLE == 0) ? S_MEASURE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE - 1)) begin
                    tmr_d   = '0;
                    state_d = S_MEASURE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_MEASURE: begin
                // First window cycle restarts the count but keeps its own edge.
                cnt_d = (tmr_q == '0) ? CNT_W'(rise) : cnt_inc;
                if (tmr_q == TMR_W'(WINDOW - 1)) begin
                    tmr_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_CHECK: begin
                last_d = cnt_q;
                tmr_d  = '0;
                if (!in_range) begin
                    state_d = S_FAIL;
                end else if (rnd_q == RND_W'(ROUNDS - 1)) begin
                    state_d = S_PASS;
                end else begin
                    rnd_d   = rnd_q + 1'b1;
                    state_d = S_MEASURE;
                end
            end
            default: ;
        endcase

        // Upstream dropping out overrides every in-progress decision.
        if (!from_up_pass &&
            (state_q == S_SETTLE || state_q == S_MEASURE || state_q == S_CHECK)) begin
            state_d = S_IDLE;
            tmr_d   = '0;
            cnt_d   = '0;
            rnd_d   = '0;
            last_d  = last_q;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            rnd_q   <= '0;
            mon_q   <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rnd_q   <= rnd_d;
            mon_q   <= mon_sig;
            pass_q  <= (state_d == S_PASS);
            fail_q  <= (state_d == S_FAIL);
            busy_q  <= (state_d == S_SETTLE) || (state_d == S_MEASURE) ||
                       (state_d == S_CHECK);
        end
    end

    assign to_down_pass = pass_q;
    assign fail         = fail_q;
    assign busy         = busy_q;
    assign last_count   = last_q;
    assign round_idx    = rnd_q;

endmodule

// File: doc/tu_clock_rate_check.md
TU_CLOCK_RATE_CHECK -- requirements
Module: tu_clock_rate_check

Interface
REQ-001 SHALL have parameter WINDOW, default 1024: clock cycles per measurement window.
REQ-002 SHALL have parameter ROUNDS, default 4: consecutive windows that must pass.
REQ-003 SHALL have parameter SETTLE, default 16: idle cycles before the first window.
REQ-004 SHALL have parameter EXP_MIN, default 100: minimum accepted edge count per window, inclusive.
REQ-005 SHALL have parameter EXP_MAX, default 140: maximum accepted edge count per window, inclusive.
REQ-006 SHALL have parameter CNT_W, default 16: edge-counter width.
REQ-007 SHALL have port clock, input, 1: the single clock of the block.
REQ-008 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-009 SHALL have port from_up_pass, input, 1: upstream test-unit pass level.
REQ-010 SHALL have port mon_sig, input, 1: monitored strobe, synchronous to clock.
REQ-011 SHALL have port to_down_pass, output, 1: pass level to the downstream test unit.
REQ-012 SHALL have port fail, output, 1: sticky failure flag.
REQ-013 SHALL have port busy, output, 1: high in SETTLE, MEASURE and CHECK.
REQ-014 SHALL have port last_count, output, CNT_W: edge count of the most recent completed window.
REQ-015 SHALL have port round_idx, output, $clog2(ROUNDS)+1: index of the current round.

Function
REQ-016 SHALL implement the states IDLE, SETTLE, MEASURE, CHECK, PASS and FAIL; all outputs SHALL be registered.
REQ-017 SHALL register mon_q <= mon_sig every cycle in every state; a rising edge SHALL be defined as mon_sig & ~mon_q.
REQ-018 In IDLE, when from_up_pass is sampled high, the block SHALL enter SETTLE on the next cycle.
REQ-019 SETTLE SHALL last exactly SETTLE cycles and then enter MEASURE.
REQ-020 MEASURE SHALL last exactly WINDOW cycles; on its first cycle the edge counter SHALL be cleared, then include that cycle's edge.
REQ-021 The edge counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-022 CHECK SHALL last one cycle: last_count SHALL take the final window count, and the window SHALL be compared against EXP_MIN and EXP_MAX.
- In range with round_idx == ROUNDS-1: the block SHALL enter PASS.
- In range otherwise: round_idx SHALL increment and the block SHALL enter MEASURE directly, with no SETTLE.
- Out of range: the block SHALL enter FAIL.
REQ-023 PASS SHALL assert to_down_pass=1; PASS SHALL be terminal and sticky until rst.
REQ-024 FAIL SHALL assert fail=1 with to_down_pass=0; FAIL SHALL be terminal and sticky until rst.
REQ-025 If from_up_pass is low during SETTLE, MEASURE or CHECK, the block SHALL enter IDLE next cycle, clearing round_idx and the counters; last_count SHALL be retained.
REQ-026 If from_up_pass is low in the same cycle as a CHECK, the abort SHALL take priority over PASS, FAIL and the round increment.
REQ-027 In PASS and FAIL, from_up_pass SHALL be ignored.
REQ-028 Timing: with from_up_pass sampled high at cycle 0, to_down_pass SHALL rise at cycle SETTLE + ROUNDS*(WINDOW+1) + 1.

Reset
REQ-029 rst SHALL act asynchronously: state=IDLE, to_down_pass=0, fail=0, busy=0, last_count=0, round_idx=0, counters=0, mon_q=0.
REQ-030 Assertion of rst in any state, including mid-window, SHALL abort immediately.
REQ-031 After rst release the block SHALL wait in IDLE for from_up_pass.

Verification
Parameters for all scenarios: WINDOW=16, ROUNDS=2, SETTLE=4, EXP_MIN=3, EXP_MAX=5, CNT_W=8.
REQ-032 Pass path: mon_sig toggles every 2 cycles (4 edges/window); from_up_pass=1 at cycle 0 -> to_down_pass=1 at cycle 39, last_count=4, fail=0, busy=0.
REQ-033 Stuck monitor: mon_sig=0 -> fail=1 at cycle 22, last_count=0, to_down_pass remains 0.
REQ-034 Too fast: mon_sig toggles every cycle (8 edges/window) -> fail=1 after the first CHECK, last_count=8; with CNT_W=3 instead, last_count=7 (saturated).
REQ-035 Abort: drop from_up_pass at cycle 10 (MEASURE) -> busy=0 and IDLE at cycle 11, round_idx=0; reassert at cycle 20 -> to_down_pass rises 39 cycles later.
REQ-036 Async reset: pulse rst mid-way through the second window -> all outputs 0 immediately, without waiting for a clock edge; from_up_pass still high at release -> the sequence restarts and passes.
